// File: rtl/jtcps1_dwnld_pkg.sv
// Shared region offsets and region tags for the CPS1 ROM download path.
// The game top uses the same offsets to place its SDRAM regions.
package jtcps1_dwnld_pkg;

    localparam int          DEF_REGSIZE    = 23;
    localparam logic [21:0] DEF_CPU_OFFSET = 22'h00_0000;
    localparam logic [21:0] DEF_SND_OFFSET = 22'h08_0000;
    localparam logic [21:0] DEF_OKI_OFFSET = 22'h08_8000;
    localparam logic [21:0] DEF_GFX_OFFSET = 22'h0A_8000;
    localparam logic [21:0] DEF_GFX_END    = 22'h3A_8000;

    typedef enum logic [2:0] {
        RGN_CPU,
        RGN_SND,
        RGN_OKI,
        RGN_GFX,
        RGN_NONE
    } region_t;

endpackage

// File: rtl/jtcps1_dwnld_map.sv
// Combinational decode of a file byte address into an SDRAM word, lane mask and region.
// RGN_NONE marks header bytes and bytes that would land at or above GFX_END.
module jtcps1_dwnld_map
    import jtcps1_dwnld_pkg::*;
#(
    parameter int          REGSIZE    = DEF_REGSIZE,
    parameter logic [21:0] CPU_OFFSET = DEF_CPU_OFFSET,
    parameter logic [21:0] SND_OFFSET = DEF_SND_OFFSET,
    parameter logic [21:0] OKI_OFFSET = DEF_OKI_OFFSET,
    parameter logic [21:0] GFX_OFFSET = DEF_GFX_OFFSET,
    parameter logic [21:0] GFX_END    = DEF_GFX_END
) (
    input  logic [22:0] ioctl_addr,
    output logic        header,
    output region_t     region,
    output logic [21:0] word_addr,
    output logic [1:0]  mask
);

    localparam logic [22:0] REG_B     = 23'(REGSIZE);
    localparam logic [22:0] SND_START = {SND_OFFSET - CPU_OFFSET, 1'b0};
    localparam logic [22:0] OKI_START = {OKI_OFFSET - CPU_OFFSET, 1'b0};
    localparam logic [22:0] GFX_START = {GFX_OFFSET - CPU_OFFSET, 1'b0};

    logic [22:0] b, rel, base, word_full;
    logic        upper;

    always_comb begin
        b      = ioctl_addr - REG_B;
        header = ioctl_addr < REG_B;
        rel    = b;
        base   = {1'b0, CPU_OFFSET};
        region = RGN_CPU;
        if (b >= GFX_START) begin
            rel    = b - GFX_START;
            base   = {1'b0, GFX_OFFSET};
            region = RGN_GFX;
        end else if (b >= OKI_START) begin
            rel    = b - OKI_START;
            base   = {1'b0, OKI_OFFSET};
            region = RGN_OKI;
        end else if (b >= SND_START) begin
            rel    = b - SND_START;
            base   = {1'b0, SND_OFFSET};
            region = RGN_SND;
        end
        // Compare before truncation so wrap-around can never reach the RAM area
        word_full = base + (rel >> 1);
        if (header || word_full >= {1'b0, GFX_END}) region = RGN_NONE;
        word_addr = word_full[21:0];
        upper     = (region == RGN_CPU) ? ~b[0] : b[0];
        mask      = upper ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/jtcps1_dwnld.sv
// Byte-serial ROM download to SDRAM word writes, with CPS-B header forwarding.
// One active request plus one skid entry absorb the SDRAM acknowledge latency.
module jtcps1_dwnld
    import jtcps1_dwnld_pkg::*;
#(
    parameter int          REGSIZE    = DEF_REGSIZE,
    parameter logic [21:0] CPU_OFFSET = DEF_CPU_OFFSET,
    parameter logic [21:0] SND_OFFSET = DEF_SND_OFFSET,
    parameter logic [21:0] OKI_OFFSET = DEF_OKI_OFFSET,
    parameter logic [21:0] GFX_OFFSET = DEF_GFX_OFFSET,
    parameter logic [21:0] GFX_END    = DEF_GFX_END
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [22:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    input  logic        sdram_ack,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    output logic        cfg_we,
    output logic        busy,
    output logic        overrun
);

    // state | meaning
    // IDLE  | no request loaded
    // WAIT  | prog_we high, waiting for sdram_ack
    // HOLD  | next request loaded, one low cycle before raising prog_we
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state;
    logic        header;
    region_t     region;
    logic [21:0] map_addr;
    logic [1:0]  map_mask;
    logic        strobe, hdr_in, rom_in, dl_q;
    logic        skid_v;
    logic [21:0] skid_addr;
    logic [7:0]  skid_data, req_data, hdr_data;
    logic [1:0]  skid_mask;

    jtcps1_dwnld_map #(
        .REGSIZE    (REGSIZE),
        .CPU_OFFSET (CPU_OFFSET),
        .SND_OFFSET (SND_OFFSET),
        .OKI_OFFSET (OKI_OFFSET),
        .GFX_OFFSET (GFX_OFFSET),
        .GFX_END    (GFX_END)
    ) u_map (
        .ioctl_addr (ioctl_addr),
        .header     (header),
        .region     (region),
        .word_addr  (map_addr),
        .mask       (map_mask)
    );

    assign strobe    = downloading & ioctl_wr;
    assign hdr_in    = strobe & header;
    assign rom_in    = strobe & (region != RGN_NONE);
    assign prog_data = cfg_we ? hdr_data : req_data;
    assign busy      = prog_we | skid_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            prog_addr <= '0;
            prog_mask <= 2'b11;
            prog_we   <= 1'b0;
            req_data  <= '0;
            hdr_data  <= '0;
            cfg_we    <= 1'b0;
            overrun   <= 1'b0;
            dl_q      <= 1'b0;
            skid_v    <= 1'b0;
            skid_addr <= '0;
            skid_data <= '0;
            skid_mask <= 2'b11;
        end else begin
            dl_q   <= downloading;
            cfg_we <= hdr_in;
            if (hdr_in) hdr_data <= ioctl_data;
            if (downloading && !dl_q) overrun <= 1'b0;
            case (state)
                ST_IDLE: if (rom_in) begin
                    prog_addr <= map_addr;
                    prog_mask <= map_mask;
                    req_data  <= ioctl_data;
                    prog_we   <= 1'b1;
                    state     <= ST_WAIT;
                end
                ST_WAIT: if (sdram_ack) begin
                    prog_we <= 1'b0;
                    if (skid_v) begin
                        // skid moves up; a byte arriving with the ack takes its place
                        prog_addr <= skid_addr;
                        prog_mask <= skid_mask;
                        req_data  <= skid_data;
                        skid_v    <= rom_in;
                        skid_addr <= map_addr;
                        skid_mask <= map_mask;
                        skid_data <= ioctl_data;
                        state     <= ST_HOLD;
                    end else if (rom_in) begin
                        prog_addr <= map_addr;
                        prog_mask <= map_mask;
                        req_data  <= ioctl_data;
                        state     <= ST_HOLD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end else if (rom_in) begin
                    if (skid_v) begin
                        overrun <= 1'b1;
                    end else begin
                        skid_v    <= 1'b1;
                        skid_addr <= map_addr;
                        skid_mask <= map_mask;
                        skid_data <= ioctl_data;
                    end
                end
                ST_HOLD: begin
                    prog_we <= 1'b1;
                    state   <= ST_WAIT;
                    if (rom_in) begin
                        if (skid_v) begin
                            overrun <= 1'b1;
                        end else begin
                            skid_v    <= 1'b1;
                            skid_addr <= map_addr;
                            skid_mask <= map_mask;
                            skid_data <= ioctl_data;
                        end
                    end
                end
                default: begin
                    prog_we <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtcps1_dwnld.sv
// Bench for jtcps1_dwnld: vector table, directed corner sequences and a randomized
// run against a queue-based model of the download-to-SDRAM mapping and two-deep buffering.
module tb_jtcps1_dwnld;

    logic        clk = 1'b0;
    logic        rst, downloading, ioctl_wr, sdram_ack;
    logic [22:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we, cfg_we, busy, overrun;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jtcps1_dwnld dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .sdram_ack   (sdram_ack),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_we     (prog_we),
        .cfg_we      (cfg_we),
        .busy        (busy),
        .overrun     (overrun)
    );

    typedef struct {
        logic [21:0] a;
        logic [7:0]  d;
        logic [1:0]  m;
    } req_t;

    typedef struct {
        logic [22:0] addr;
        logic [7:0]  data;
        logic [21:0] word;
        logic [1:0]  mask;
        bit          drop;
    } vec_t;

    req_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // File byte -> SDRAM word from the region table: each region starts at a byte
    // offset past the header and fills words from its base; only CPU is big-endian.
    function automatic void ref_map(input int unsigned a, output bit keep,
                                    output int unsigned w, output bit [1:0] m);
        int unsigned bofs = a - 23;
        int unsigned starts[4] = '{32'h0, 32'h100000, 32'h110000, 32'h150000};
        int unsigned bases[4]  = '{32'h0, 32'h80000, 32'h88000, 32'hA8000};
        int r = 0;
        bit upper;
        for (int i = 0; i < 4; i++) if (bofs >= starts[i]) r = i;
        w = bases[r] + (bofs - starts[r]) / 2;
        upper = (r == 0) ? (bofs % 2 == 0) : (bofs % 2 == 1);
        m = upper ? 2'b01 : 2'b10;
        keep = w < 32'h3A8000;
    endfunction

    task automatic strobe(input logic [22:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    task automatic serve(input string nm, input logic [21:0] a, input logic [7:0] d,
                         input logic [1:0] m);
        int n = 0;
        while (!prog_we && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_we"}, prog_we, 1);
        if (!prog_we) return;
        chk({nm, "_addr"}, prog_addr, a);
        chk({nm, "_data"}, prog_data, d);
        chk({nm, "_mask"}, prog_mask, m);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        chk({nm, "_fall"}, prog_we, 0);
    endtask

    task automatic random_run();
        bit          prev_ack = 1'b0;
        bit          exp_ovr  = 1'b0;
        bit          keep;
        int unsigned w;
        bit [1:0]    m;
        int unsigned a;
        req_t        r;
        int unsigned picks[5] = '{32'h0FFFC0, 32'h10FFC0, 32'h14FFC0, 32'h150000, 32'h74FFC0};
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (prev_ack) chk("rnd_gap", prog_we, 0);
            if (prog_we) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected_we", prog_we, 0);
                end else begin
                    chk("rnd_addr", prog_addr, q[0].a);
                    chk("rnd_data", prog_data, q[0].d);
                    chk("rnd_mask", prog_mask, q[0].m);
                end
            end
            chk("rnd_ovr", overrun, exp_ovr);
            sdram_ack = prog_we && ($urandom_range(0, 2) == 0);
            if (sdram_ack && q.size() > 0) void'(q.pop_front());
            prev_ack = sdram_ack;
            ioctl_wr = (cyc < 500) && ($urandom_range(0, 3) == 0);
            if (ioctl_wr) begin
                a = 23 + picks[$urandom_range(0, 4)] + $urandom_range(0, 127);
                ioctl_addr = a[22:0];
                ioctl_data = 8'($urandom);
                ref_map(a, keep, w, m);
                if (keep) begin
                    if (q.size() < 2) begin
                        r.a = w[21:0];
                        r.d = ioctl_data;
                        r.m = m;
                        q.push_back(r);
                    end else begin
                        exp_ovr = 1'b1;
                    end
                end
            end
            @(negedge clk);
        end
        ioctl_wr  = 1'b0;
        sdram_ack = 1'b0;
        chk("rnd_drain", q.size(), 0);
        chk("rnd_busy_end", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[10];
        int   hi;
        bit   seen;

        vt[0] = '{23'h000017, 8'h12, 22'h000000, 2'b01, 1'b0};
        vt[1] = '{23'h000018, 8'h34, 22'h000000, 2'b10, 1'b0};
        vt[2] = '{23'h100016, 8'hA5, 22'h07FFFF, 2'b10, 1'b0};
        vt[3] = '{23'h100017, 8'h5A, 22'h080000, 2'b10, 1'b0};
        vt[4] = '{23'h100018, 8'h77, 22'h080000, 2'b01, 1'b0};
        vt[5] = '{23'h110017, 8'h3C, 22'h088000, 2'b10, 1'b0};
        vt[6] = '{23'h150017, 8'hC3, 22'h0A8000, 2'b10, 1'b0};
        vt[7] = '{23'h750016, 8'h9E, 22'h3A7FFF, 2'b01, 1'b0};
        vt[8] = '{23'h750017, 8'h11, 22'h000000, 2'b11, 1'b1};
        vt[9] = '{23'h7FFFFF, 8'h22, 22'h000000, 2'b11, 1'b1};

        rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0; sdram_ack = 1'b0;
        ioctl_addr = '0; ioctl_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_prog_we", prog_we, 0);
        chk("rst_cfg_we", cfg_we, 0);
        chk("rst_mask", prog_mask, 2'b11);
        chk("rst_addr", prog_addr, 0);
        chk("rst_data", prog_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        @(negedge clk);

        strobe(23'h000017, 8'h99);
        chk("ign_rom_we", prog_we, 0);
        strobe(23'h000005, 8'h55);
        chk("ign_hdr_cfg", cfg_we, 0);

        downloading = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 23; i++) begin
            ioctl_addr = 23'(i);
            ioctl_data = 8'(i);
            ioctl_wr   = 1'b1;
            @(negedge clk);
            chk("hdr_cfg_we", cfg_we, 1);
            chk("hdr_data", prog_data, i);
            chk("hdr_prog_we", prog_we, 0);
        end
        ioctl_wr = 1'b0;
        @(negedge clk);
        chk("hdr_cfg_end", cfg_we, 0);
        chk("hdr_we_end", prog_we, 0);

        for (int v = 0; v < 10; v++) begin
            strobe(vt[v].addr, vt[v].data);
            if (vt[v].drop) begin
                for (int k = 0; k < 3; k++) begin
                    chk("vec_drop_we", prog_we, 0);
                    chk("vec_drop_busy", busy, 0);
                    @(negedge clk);
                end
            end else begin
                chk("vec_latency", prog_we, 1);
                chk("vec_addr", prog_addr, vt[v].word);
                chk("vec_data", prog_data, vt[v].data);
                chk("vec_mask", prog_mask, vt[v].mask);
                hi = 0;
                for (int k = 0; k < 12 && prog_we; k++) begin
                    hi++;
                    sdram_ack = (hi == 4);
                    @(negedge clk);
                    sdram_ack = 1'b0;
                end
                chk("vec_we_cycles", hi, 4);
                chk("vec_we_fall", prog_we, 0);
                @(negedge clk);
            end
        end
        chk("vec_no_overrun", overrun, 0);

        ioctl_addr = 23'h000017; ioctl_data = 8'hA1; ioctl_wr = 1'b1;
        @(negedge clk);
        ioctl_addr = 23'h000018; ioctl_data = 8'hA2;
        @(negedge clk);
        ioctl_addr = 23'h000019; ioctl_data = 8'hA3;
        @(negedge clk);
        ioctl_wr = 1'b0;
        chk("ovr_set", overrun, 1);
        chk("ovr_busy", busy, 1);
        serve("ovr_first", 22'h000000, 8'hA1, 2'b01);
        serve("ovr_second", 22'h000000, 8'hA2, 2'b10);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (prog_we) seen = 1'b1;
        end
        chk("ovr_third_dropped", seen, 0);
        chk("ovr_sticky", overrun, 1);
        downloading = 1'b0;
        @(negedge clk);
        chk("ovr_hold_low", overrun, 1);
        downloading = 1'b1;
        @(negedge clk);
        chk("ovr_clear_rise", overrun, 0);

        strobe(23'h100019, 8'hB1);
        strobe(23'h10001A, 8'hB2);
        chk("sim_active_addr", prog_addr, 22'h080001);
        chk("sim_active_data", prog_data, 8'hB1);
        ioctl_addr = 23'h10001B; ioctl_data = 8'hB3; ioctl_wr = 1'b1; sdram_ack = 1'b1;
        @(negedge clk);
        ioctl_wr = 1'b0; sdram_ack = 1'b0;
        chk("sim_gap", prog_we, 0);
        chk("sim_no_ovr", overrun, 0);
        serve("sim_second", 22'h080001, 8'hB2, 2'b01);
        serve("sim_third", 22'h080002, 8'hB3, 2'b10);
        chk("sim_no_ovr_end", overrun, 0);
        chk("sim_idle_busy", busy, 0);

        strobe(23'h750017, 8'hC1);
        for (int k = 0; k < 3; k++) begin
            chk("prot_we", prog_we, 0);
            chk("prot_busy", busy, 0);
            @(negedge clk);
        end
        chk("prot_no_ovr", overrun, 0);

        strobe(23'h150019, 8'hC2);
        chk("rstw_we", prog_we, 1);
        chk("rstw_addr", prog_addr, 22'h0A8001);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_we_low", prog_we, 0);
        chk("rstw_busy_low", busy, 0);
        chk("rstw_mask", prog_mask, 2'b11);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (prog_we) seen = 1'b1;
        end
        chk("rstw_no_write", seen, 0);

        random_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtcps1_dwnld.md
Name: jtcps1_dwnld

Overview:
- Upstream stage of the CPS1 game top: converts the byte-serial ROM download stream (ioctl) into SDRAM word-write requests (prog_*).
- Strips a REGSIZE-byte header and forwards it serially to the CPS-B configuration registers via cfg_we.
- Maps the remaining file bytes onto the CPU, sound, ADPCM and GFX SDRAM regions.
- Absorbs SDRAM acknowledge latency with a one-entry skid buffer.

Parameters:
- REGSIZE, 23: number of header bytes forwarded on cfg_we.
- CPU_OFFSET, 22'h00_0000: SDRAM word address of the CPU ROM region.
- SND_OFFSET, 22'h08_0000: SDRAM word address of the Z80 ROM region. It also ends the CPU region.
- OKI_OFFSET, 22'h08_8000: SDRAM word address of the ADPCM region.
- GFX_OFFSET, 22'h0A_8000: SDRAM word address of the GFX region.
- GFX_END, 22'h3A_8000: first word address past GFX. It protects the RAM/VRAM area.

Ports:
- clk  in  1  system clock (48 MHz domain). Single clock.
- rst  in  1  reset. Synchronous, active-high.
- downloading  in  1  download window active.
- ioctl_addr  in  23  byte address in the file.
- ioctl_data  in  8  file byte.
- ioctl_wr  in  1  one-cycle byte strobe.
- sdram_ack  in  1  SDRAM controller accepted the current prog write.
- prog_addr  out  22  SDRAM word address.
- prog_data  out  8  byte to write. It is also the header byte when cfg_we is high.
- prog_mask  out  2  active-low byte enable. [1]=upper byte, [0]=lower byte.
- prog_we  out  1  write request. Held until acknowledged.
- cfg_we  out  1  one-cycle header-byte strobe.
- busy  out  1  a request is pending or buffered.
- overrun  out  1  sticky: a byte was lost because both buffer entries were full.

Behaviour:
- Reset values: all outputs 0. prog_mask resets to 2'b11. Buffer empty, state IDLE.
- Reset mid-operation drops all pending requests.
- overrun clears only on rst, or on a rising edge of downloading.

Strobe acceptance:
- ioctl_wr counts only when downloading=1. Otherwise it is ignored.

Header bytes (ioctl_addr < REGSIZE):
- cfg_we pulses exactly one cycle, the cycle after ioctl_wr.
- prog_data shows the byte in that same cycle.
- prog_we is not raised.
- Header bytes bypass the buffer. When cfg_we pulses, prog_data carries the header byte while prog_we stays 0.

ROM bytes, address mapping (b = ioctl_addr - REGSIZE, 23-bit):
- CPU region, b < 2*(SND_OFFSET-CPU_OFFSET):
  - word = CPU_OFFSET + b[22:1].
  - Big-endian: b[0]=0 gives mask 2'b01 (upper byte); b[0]=1 gives 2'b10.
- Sound region, b below 2*(OKI_OFFSET-CPU_OFFSET):
  - word = SND_OFFSET + (b - 2*(SND_OFFSET-CPU_OFFSET))>>1.
  - Little-endian: b[0]=0 gives mask 2'b10.
- ADPCM region, b below 2*(GFX_OFFSET-CPU_OFFSET): same rule as the sound region, based at OKI_OFFSET.
- GFX region: linear from GFX_OFFSET, little-endian byte lanes.
- Any computed word >= GFX_END: byte silently discarded. No prog_we, no overrun.
- Region offset arithmetic is 23-bit. The result is truncated to 22 bits only after the GFX_END compare.

Request state machine:
- IDLE: buffer entry valid → load prog_addr/prog_data/prog_mask, set prog_we next cycle, go to WAIT.
- WAIT: prog_we stays high with stable address, data and mask until sdram_ack=1.
  - The cycle after ack: prog_we=0, return to IDLE.
  - An ack arriving in IDLE is ignored.
- Latency: ioctl_wr at cycle N with an empty buffer → prog_we=1 at N+1.
- Back-to-back requests are separated by at least one cycle with prog_we=0.

Buffering:
- Two slots: the active request plus one skid entry.
- A byte arriving while both are occupied is dropped and overrun is set.
- A byte arriving in the same cycle the ack frees a slot is accepted: the skid entry moves up and the new byte takes the skid slot.

End of download and busy:
- downloading falling with requests pending: they still complete normally.
- busy = prog_we OR skid entry valid.

Decomposition:
- Package jtcps1_dwnld_pkg: region offset constants (shared with the game top's localparams) and region enum CPU/SND/OKI/GFX/NONE.
- Natural sub-module: jtcps1_dwnld_map, purely combinational. It takes byte address → {region, word address, mask, discard}.
- FSM and skid buffer live in the parent.

Test Plan:
1. Header forwarding: stream 23 header bytes 0x00..0x16 → 23 cfg_we pulses with matching prog_data; prog_we never rises.
2. CPU byte lanes: ioctl_addr=23 data 0x12, then ioctl_addr=24 data 0x34, ack 3 cycles after each request → two writes to word 0x000000 with mask 2'b01/0x12 then 2'b10/0x34; prog_we high 4 cycles each.
3. Region boundary: byte b=0x0FFFFF → CPU word 0x07FFFF, mask 2'b10; byte b=0x100000 → word 0x080000 (SND_OFFSET), mask 2'b10.
4. Overrun: hold sdram_ack=0 and send 3 ROM bytes → first is active, second is buffered, third is dropped and overrun=1; after ack both survivors complete in order, and overrun stays 1.
5. Simultaneous event: send a new byte in the same cycle as sdram_ack with the skid buffer full → no overrun, all 3 bytes written.
6. Protection and reset: a byte mapping to word 0x3A8000 gives no prog_we; rst asserted mid-WAIT → prog_we=0 and busy=0 next cycle, no later write.
